// File: rtl/svga_timing_gen_if.sv
// Raster timing bus: pixel enable in, coordinates plus sync/active strobes out.
// The generator drives through master; the draw pipeline or display side uses slave.
interface svga_timing_gen_if;
    logic        i_pix_ce;
    logic [10:0] o_current_x;
    logic [10:0] o_current_y;
    logic        o_active;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_line_start;
    logic        o_frame_start;
    logic        o_active_d;
    logic        o_hsync_d;
    logic        o_vsync_d;

    modport master (
        input  i_pix_ce,
        output o_current_x, o_current_y, o_active, o_hsync, o_vsync,
               o_line_start, o_frame_start, o_active_d, o_hsync_d, o_vsync_d
    );

    modport slave (
        output i_pix_ce,
        input  o_current_x, o_current_y, o_active, o_hsync, o_vsync,
               o_line_start, o_frame_start, o_active_d, o_hsync_d, o_vsync_d
    );
endinterface

// File: rtl/svga_timing_gen.sv
// Raster timing generator: x/y pixel counters, registered sync/active decode,
// line/frame start pulses and a delay line aligning syncs with the draw pipeline.
module svga_timing_gen #(
    parameter int H_VIS    = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int PIPE_DLY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    svga_timing_gen_if.master      bus
);

    localparam logic [10:0] H_LAST     = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST     = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_VIS_W    = 11'(H_VIS);
    localparam logic [10:0] V_VIS_W    = 11'(V_VIS);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VIS + V_FP + V_SYNC);

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vid_t;

    localparam vid_t VID_IDLE = vid_t'{1'b0, ~H_POL, ~V_POL};

    logic [10:0] r_x, r_y;
    logic        r_active, r_hsync, r_vsync;
    logic        r_line_start, r_frame_start;

    logic        w_x_wrap, w_y_wrap;
    logic [10:0] w_x_nxt, w_y_nxt;
    vid_t        w_vid_nxt;

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);

    // Strobes are decoded from the next coordinates so the registered copies
    // line up with the registered counters in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_x_nxt = r_x + 11'd1;
        w_y_nxt = r_y;
        if (w_x_wrap) begin
            w_x_nxt = '0;
            w_y_nxt = w_y_wrap ? '0 : r_y + 11'd1;
        end
        w_vid_nxt.active = (w_x_nxt < H_VIS_W) && (w_y_nxt < V_VIS_W);
        w_vid_nxt.hsync  = ((w_x_nxt >= H_SYNC_BEG) && (w_x_nxt < H_SYNC_END)) ? H_POL : ~H_POL;
        w_vid_nxt.vsync  = ((w_y_nxt >= V_SYNC_BEG) && (w_y_nxt < V_SYNC_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b1;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_line_start  <= bus.i_pix_ce & w_x_wrap;
            r_frame_start <= bus.i_pix_ce & w_x_wrap & w_y_wrap;
            if (bus.i_pix_ce) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_active <= w_vid_nxt.active;
                r_hsync  <= w_vid_nxt.hsync;
                r_vsync  <= w_vid_nxt.vsync;
            end
        end
    end

    assign bus.o_current_x   = r_x;
    assign bus.o_current_y   = r_y;
    assign bus.o_active      = r_active;
    assign bus.o_hsync       = r_hsync;
    assign bus.o_vsync       = r_vsync;
    assign bus.o_line_start  = r_line_start;
    assign bus.o_frame_start = r_frame_start;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign bus.o_active_d = r_active;
            assign bus.o_hsync_d  = r_hsync;
            assign bus.o_vsync_d  = r_vsync;
        end else begin : g_dly
            vid_t r_dly [PIPE_DLY];

            // Shifts every clk, independent of the pixel enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: the few delay stages are reset so the delayed strobes start idle, not X.
                    for (int i = 0; i < PIPE_DLY; i++) r_dly[i] <= VID_IDLE;
                end else begin
                    r_dly[0] <= vid_t'{r_active, r_hsync, r_vsync};
                    for (int i = 1; i < PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign bus.o_active_d = r_dly[PIPE_DLY-1].active;
            assign bus.o_hsync_d  = r_dly[PIPE_DLY-1].hsync;
            assign bus.o_vsync_d  = r_dly[PIPE_DLY-1].vsync;
        end
    endgenerate

endmodule
